// File: rtl/noc_packetizer_if.sv
// Handshake bundle between a tile's request source, the packetizer and the
// router's local input port.
interface noc_packetizer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_dest_x;
   logic [3:0]  req_dest_y;
   logic [2:0]  req_len_m1;
   logic [31:0] req_addr;
   logic        pay_valid;
   logic        pay_ready;
   logic [63:0] pay_data;
   logic [63:0] flit_out;
   logic        valid_out;
   logic        ready_in;
   logic        busy;
   logic [15:0] pkt_count;

   // master: request source and router side (drives requests, payload, ready_in)
   modport master (
      output req_valid, req_dest_x, req_dest_y, req_len_m1, req_addr,
      output pay_valid, pay_data, ready_in,
      input  req_ready, pay_ready, flit_out, valid_out, busy, pkt_count
   );

   // slave: the packetizer itself
   modport slave (
      input  req_valid, req_dest_x, req_dest_y, req_len_m1, req_addr,
      input  pay_valid, pay_data, ready_in,
      output req_ready, pay_ready, flit_out, valid_out, busy, pkt_count
   );
endinterface

// File: rtl/noc_packetizer.sv
// Turns one write request plus 1-8 payload words into a wormhole packet
// (head flit + body flits) for the router's local port.
//
// state | meaning
// IDLE  | waiting for a request; head flit loaded on acceptance
// BODY  | forwarding payload words until rem reaches zero
module noc_packetizer #(
   parameter logic [3:0] SRC_X = 4'd0,
   parameter logic [3:0] SRC_Y = 4'd0
) (
   input logic             clk,
   input logic             rst_n,
   noc_packetizer_if.slave bus
);

   typedef enum logic {IDLE, BODY} state_t;

   state_t      state, state_n;
   logic [3:0]  rem, rem_n;
   logic [63:0] flit, flit_n;
   logic        valid, valid_n;
   logic [15:0] pkt_cnt, pkt_cnt_n;
   logic        slot_free;
   logic        load;
   logic        req_rdy, pay_rdy;

   // A held flit blocks new loads until the router takes it.
   assign slot_free = !valid || bus.ready_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rem     <= 4'd0;
         flit    <= 64'd0;
         valid   <= 1'b0;
         pkt_cnt <= 16'd0;
      end else begin
         state   <= state_n;
         rem     <= rem_n;
         flit    <= flit_n;
         valid   <= valid_n;
         pkt_cnt <= pkt_cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      rem_n     = rem;
      flit_n    = flit;
      pkt_cnt_n = pkt_cnt;
      load      = 1'b0;
      req_rdy   = 1'b0;
      pay_rdy   = 1'b0;
      case (state)
         IDLE: begin
            req_rdy = slot_free;
            if (bus.req_valid && slot_free) begin
               load    = 1'b1;
               flit_n  = {bus.req_dest_x, bus.req_dest_y, SRC_X, SRC_Y,
                          1'b0, bus.req_len_m1, 12'h000, bus.req_addr};
               rem_n   = {1'b0, bus.req_len_m1} + 4'd1;
               state_n = BODY;
            end
         end
         BODY: begin
            pay_rdy = slot_free;
            if (bus.pay_valid && slot_free) begin
               load   = 1'b1;
               flit_n = bus.pay_data;
               rem_n  = rem - 4'd1;
               if (rem == 4'd1) begin
                  state_n   = IDLE;
                  pkt_cnt_n = pkt_cnt + 16'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      valid_n = load || (valid && !bus.ready_in);
   end

   assign bus.req_ready = req_rdy;
   assign bus.pay_ready = pay_rdy;
   assign bus.flit_out  = flit;
   assign bus.valid_out = valid;
   assign bus.busy      = (state == BODY) || valid;
   assign bus.pkt_count = pkt_cnt;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed self-checking bench for noc_packetizer (SRC_X=1, SRC_Y=0).
module tb_noc_packetizer;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   noc_packetizer_if bus ();

   noc_packetizer #(.SRC_X(4'd1), .SRC_Y(4'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid  = 1'b0;
      bus.req_dest_x = 4'd0;
      bus.req_dest_y = 4'd0;
      bus.req_len_m1 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.pay_valid  = 1'b0;
      bus.pay_data   = 64'd0;
      bus.ready_in   = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      vectors++;
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.valid_out); end
      vectors++;
      if (bus.flit_out !== 64'd0) begin miscompares++; $display("FAIL reset_flit got %h exp 0", bus.flit_out); end
      vectors++;
      if (bus.pkt_count !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got %h exp 0", bus.pkt_count); end
      vectors++;
      if (bus.req_ready !== 1'b1 || bus.pay_ready !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready got req=%b pay=%b busy=%b exp 1 0 0", bus.req_ready, bus.pay_ready, bus.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      bus.ready_in   = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_dest_x = 4'd3;
      bus.req_dest_y = 4'd2;
      bus.req_len_m1 = 3'd0;
      bus.req_addr   = 32'h0000_1000;
      bus.pay_valid  = 1'b1;
      bus.pay_data   = 64'hDEAD_BEEF_0000_0001;
      vectors++;
      if (bus.req_ready !== 1'b1 || bus.pay_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single_idle_ready got req=%b pay=%b exp 1 0", bus.req_ready, bus.pay_ready);
      end
      step();
      bus.req_valid = 1'b0;
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'h3210_0000_0000_1000) begin
         miscompares++;
         $display("FAIL single_head got v=%b %h exp 1 3210000000001000", bus.valid_out, bus.flit_out);
      end
      vectors++;
      if (bus.pay_ready !== 1'b1 || bus.req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single_body_ready got pay=%b req=%b exp 1 0", bus.pay_ready, bus.req_ready);
      end
      step();
      bus.pay_valid = 1'b0;
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'hDEAD_BEEF_0000_0001) begin
         miscompares++;
         $display("FAIL single_body got v=%b %h exp 1 deadbeef00000001", bus.valid_out, bus.flit_out);
      end
      vectors++;
      if (bus.pkt_count !== 16'd1) begin miscompares++; $display("FAIL single_cnt got %0d exp 1", bus.pkt_count); end
      step();
      vectors++;
      if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_drain got v=%b busy=%b exp 0 0", bus.valid_out, bus.busy);
      end
   endtask

   task automatic test_max_len();
      bus.ready_in   = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_dest_x = 4'd5;
      bus.req_dest_y = 4'd6;
      bus.req_len_m1 = 3'd7;
      bus.req_addr   = 32'hA000_0004;
      bus.pay_valid  = 1'b1;
      bus.pay_data   = 64'd0;
      step();
      bus.req_valid = 1'b0;
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'h5610_7000_A000_0004) begin
         miscompares++;
         $display("FAIL max_head got v=%b %h exp 1 56107000a0000004", bus.valid_out, bus.flit_out);
      end
      for (int i = 0; i < 8; i++) begin
         bus.pay_data = 64'(i);
         step();
         vectors++;
         if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'(i)) begin
            miscompares++;
            $display("FAIL max_body%0d got v=%b %h exp 1 %h", i, bus.valid_out, bus.flit_out, 64'(i));
         end
      end
      bus.pay_valid = 1'b0;
      vectors++;
      if (bus.pkt_count !== 16'd2 || bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL max_end got cnt=%0d req_ready=%b exp 2 1", bus.pkt_count, bus.req_ready);
      end
      step();
   endtask

   task automatic test_backpressure();
      bus.ready_in   = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_dest_x = 4'd2;
      bus.req_dest_y = 4'd1;
      bus.req_len_m1 = 3'd1;
      bus.req_addr   = 32'h0000_0BAD;
      bus.pay_valid  = 1'b1;
      bus.pay_data   = 64'h1111;
      step();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'h2110_1000_0000_0BAD ||
             bus.pay_ready !== 1'b0 || bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d got v=%b %h pay=%b req=%b exp 1 2110100000000bad 0 0",
                     i, bus.valid_out, bus.flit_out, bus.pay_ready, bus.req_ready);
         end
         step();
      end
      bus.ready_in = 1'b1;
      step();
      bus.pay_data = 64'h2222;
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'h1111) begin
         miscompares++;
         $display("FAIL bp_body0 got v=%b %h exp 1 1111", bus.valid_out, bus.flit_out);
      end
      step();
      bus.pay_valid = 1'b0;
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'h2222 || bus.pkt_count !== 16'd3) begin
         miscompares++;
         $display("FAIL bp_body1 got v=%b %h cnt=%0d exp 1 2222 3", bus.valid_out, bus.flit_out, bus.pkt_count);
      end
      step();
      vectors++;
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL bp_drain got v=%b exp 0", bus.valid_out); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_flits [6];
      exp_flits[0] = 64'h1110_1000_0000_0100;
      exp_flits[1] = 64'hA0;
      exp_flits[2] = 64'hA1;
      exp_flits[3] = 64'h4410_1000_0000_0200;
      exp_flits[4] = 64'hB0;
      exp_flits[5] = 64'hB1;
      bus.ready_in   = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_dest_x = 4'd1;
      bus.req_dest_y = 4'd1;
      bus.req_len_m1 = 3'd1;
      bus.req_addr   = 32'h100;
      bus.pay_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 0 || i == 3) bus.pay_data = 64'd0;
         else bus.pay_data = exp_flits[i];
         step();
         if (i == 0) begin
            bus.req_dest_x = 4'd4;
            bus.req_dest_y = 4'd4;
            bus.req_addr   = 32'h200;
         end
         if (i == 3) bus.req_valid = 1'b0;
         vectors++;
         if (bus.valid_out !== 1'b1 || bus.flit_out !== exp_flits[i]) begin
            miscompares++;
            $display("FAIL b2b_flit%0d got v=%b %h exp 1 %h", i, bus.valid_out, bus.flit_out, exp_flits[i]);
         end
      end
      bus.pay_valid = 1'b0;
      vectors++;
      if (bus.pkt_count !== 16'd5) begin miscompares++; $display("FAIL b2b_cnt got %0d exp 5", bus.pkt_count); end
      step();
   endtask

   task automatic test_wrap();
      force dut.pkt_cnt = 16'hFFFF;
      #1;
      release dut.pkt_cnt;
      bus.ready_in  = 1'b1;
      bus.pay_valid = 1'b1;
      bus.pay_data  = 64'h55;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (bus.pay_ready !== 1'b0 || bus.valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_pay%0d got pay_ready=%b v=%b exp 0 0", i, bus.pay_ready, bus.valid_out);
         end
         step();
      end
      vectors++;
      if (bus.pkt_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_pre got %h exp ffff", bus.pkt_count); end
      bus.req_valid  = 1'b1;
      bus.req_dest_x = 4'd0;
      bus.req_dest_y = 4'd0;
      bus.req_len_m1 = 3'd0;
      bus.req_addr   = 32'd0;
      step();
      bus.req_valid = 1'b0;
      vectors++;
      if (bus.flit_out !== 64'h0010_0000_0000_0000) begin
         miscompares++;
         $display("FAIL wrap_head got %h exp 0010000000000000", bus.flit_out);
      end
      step();
      bus.pay_valid = 1'b0;
      vectors++;
      if (bus.flit_out !== 64'h55 || bus.pkt_count !== 16'h0000) begin
         miscompares++;
         $display("FAIL wrap_cnt got %h cnt=%h exp 55 0000", bus.flit_out, bus.pkt_count);
      end
      step();
   endtask

   task automatic test_reset_mid();
      bus.ready_in   = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_dest_x = 4'd7;
      bus.req_dest_y = 4'd7;
      bus.req_len_m1 = 3'd7;
      bus.req_addr   = 32'h1234;
      bus.pay_valid  = 1'b1;
      bus.pay_data   = 64'h77;
      step();
      bus.req_valid = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.valid_out !== 1'b0 || bus.pkt_count !== 16'd0 || bus.req_ready !== 1'b1 ||
          bus.busy !== 1'b0 || bus.pay_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst got v=%b cnt=%0d req=%b busy=%b pay=%b exp 0 0 1 0 0",
                  bus.valid_out, bus.pkt_count, bus.req_ready, bus.busy, bus.pay_ready);
      end
      bus.pay_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      bus.req_valid  = 1'b1;
      bus.req_dest_x = 4'd3;
      bus.req_dest_y = 4'd2;
      bus.req_len_m1 = 3'd0;
      bus.req_addr   = 32'h0000_1000;
      step();
      bus.req_valid = 1'b0;
      vectors++;
      if (bus.valid_out !== 1'b1 || bus.flit_out !== 64'h3210_0000_0000_1000) begin
         miscompares++;
         $display("FAIL midrst_head got v=%b %h exp 1 3210000000001000", bus.valid_out, bus.flit_out);
      end
      bus.pay_valid = 1'b1;
      bus.pay_data  = 64'h99;
      step();
      bus.pay_valid = 1'b0;
      vectors++;
      if (bus.flit_out !== 64'h99 || bus.pkt_count !== 16'd1) begin
         miscompares++;
         $display("FAIL midrst_body got %h cnt=%0d exp 99 1", bus.flit_out, bus.pkt_count);
      end
      step();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_max_len();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/noc_packetizer.md
# noc_packetizer

Network-interface injector that converts a single write transaction into a wormhole packet for the NoC router's local port. It emits one head flit carrying the route and address, followed by 1–8 payload flits. Its output drives the router's local `flit_in`/`valid_in` and takes back the router's `ready_out`. One instance sits at each tile, between the tile's request source and router port 4 (local).

## Interface
Parameters:
- SRC_X, 0, this tile's X coordinate (4 bits), inserted in every head flit
- SRC_Y, 0, this tile's Y coordinate (4 bits), inserted in every head flit

Ports:
- clk  input  1  clock; all logic is rising-edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  transaction request present
- req_ready  output  1  packetizer accepts the request this cycle
- req_dest_x  input  4  destination tile X
- req_dest_y  input  4  destination tile Y
- req_len_m1  input  3  payload flit count minus 1 (0 → 1 flit, 7 → 8 flits)
- req_addr  input  32  target address
- pay_valid  input  1  payload word present
- pay_ready  output  1  packetizer accepts the payload word this cycle
- pay_data  input  64  payload word
- flit_out  output  64  flit to the router local input
- valid_out  output  1  flit_out is valid
- ready_in  input  1  router local port can accept a flit
- busy  output  1  a packet is in progress or a flit is still held
- pkt_count  output  16  count of fully loaded packets, wraps at 2^16

## Operation
- Head flit format:
  - [63:60] dest_x
  - [59:56] dest_y
  - [55:52] SRC_X
  - [51:48] SRC_Y
  - [47] 0
  - [46:44] len_m1
  - [43:32] 0
  - [31:0] addr
- Body flits are raw pay_data, in arrival order. There is no tail marker; the receiver counts len_m1+1 body flits after the head.
- Output stage: a single register holding flit_out and valid_out.
  - It may be loaded when `slot_free = !valid_out || ready_in`.
  - A flit transfers on a cycle where valid_out && ready_in.
- FSM states: IDLE and BODY.
- IDLE:
  - req_ready = slot_free; pay_ready = 0.
  - On req_valid && req_ready: load the head flit, set rem = len_m1+1 (4-bit), go to BODY.
- BODY:
  - req_ready = 0; pay_ready = slot_free.
  - On pay_valid && pay_ready: load pay_data and decrement rem.
  - When the word loaded has rem == 1: go to IDLE and increment pkt_count.
- Holding rules:
  - Once valid_out is asserted it stays high, and flit_out stays unchanged, until a cycle with ready_in = 1.
  - valid_out falls after a transfer only if nothing new is loaded in that same cycle.
- Simultaneous events:
  - A transfer and a load in the same cycle is legal. The new flit replaces the old one with no bubble.
- busy = (state == BODY) || valid_out.
- pkt_count increments when the last body flit is loaded, not when it is transferred.
- A payload word presented in IDLE is ignored: pay_ready = 0, so it is not consumed.

## Timing
- Reset (asynchronous, effective immediately):
  - state = IDLE, rem = 0, valid_out = 0, flit_out = 0, pkt_count = 0.
  - Consequently req_ready = 1, pay_ready = 0, busy = 0.
- Reset mid-packet abandons the partial packet. The router must be reset with the packetizer.
- Latency: a request accepted at cycle N puts the head on valid_out at N+1.
- Throughput: with ready_in held at 1 and payload always valid, one flit transfers per cycle. A packet of L body flits therefore occupies L+1 cycles.
- Back-to-back packets:
  - The last body flit is loaded at cycle M.
  - req_ready = 1 at M+1, provided slot_free holds.
  - The next head can be loaded at M+1, so there is no gap.
- Backpressure:
  - While ready_in = 0 and valid_out = 1, both req_ready and pay_ready are 0.
  - Nothing is lost or duplicated.
- All ready outputs are combinational in state, valid_out and ready_in. There are no combinational paths from req_valid or pay_valid.

## Test plan
- **Reset values:** assert rst_n = 0 mid-BODY, asynchronously to clk → valid_out = 0, pkt_count = 0, req_ready = 1 without waiting for a clock edge. After release, a new request is accepted normally.
- **Single-flit packet:**
  - Stimulus: ready_in = 1; request with dest (3,2), len_m1 = 0, addr 0x0000_1000; pay_data 0xDEAD_BEEF_0000_0001. SRC_X = 1, SRC_Y = 0.
  - Response: head 0x3210_0000_0000_1000 at cycle N+1, then the payload at N+2, then pkt_count = 1.
- **Maximum length with no stall:** len_m1 = 7 with 8 payload words 0..7 → 9 consecutive valid_out cycles, body flits in order 0..7, no bubbles.
- **Backpressure:** ready_in = 0 for 5 cycles while the head is presented → flit_out stable, valid_out = 1, pay_ready = 0 throughout. Release → remaining flits follow with no loss or duplication.
- **Back-to-back requests:** two len_m1 = 1 requests held valid → 6 flits on 6 consecutive cycles (head, 2 body, head, 2 body); pkt_count = 2.
- **Wrap:**
  - Force pkt_count = 0xFFFF; complete one packet → pkt_count = 0x0000.
  - Present pay_valid in IDLE → no consumption, pay_ready = 0.
